// File: rtl/nios_memory_dp.sv
// -----------------------------------------------------------------------------
// nios_memory_dp
//   Dual-port Avalon-MM on-chip RAM for the Nios system.
//   s1 is the instruction/data master port, s2 is the DMA port; both ports
//   support full read and write with pipelined reads (readdatavalid) and
//   per-port waitrequest. After reset an optional sweep writes zero to every
//   word before any access is accepted.
//
//   Optional feature macro: NIOS_MEMORY_DP_PARITY_EN
//     When defined, every byte is stored with an even-parity bit. Parity is
//     checked on every delivered read word, and a mismatch sets the sticky
//     parity_err output. parity_err is cleared only by reset_n.
//
// Ports
//   clk               single clock for both ports
//   reset_n           asynchronous, active-low reset
//   clken             0 = freeze (no accepts, read pipeline and sweep hold)
//   sN_address        word address                     (N = 1, 2)
//   sN_chipselect     port select
//   sN_read           read request
//   sN_write          write request
//   sN_byteenable     byte-lane write enables
//   sN_writedata      write data
//   sN_readdata       read data, valid only with sN_readdatavalid
//   sN_readdatavalid  one-cycle pulse per accepted read
//   sN_waitrequest    1 = request not accepted this cycle
//   parity_err        sticky parity error (only with NIOS_MEMORY_DP_PARITY_EN)
//   busy              1 while the clear sweep runs
// -----------------------------------------------------------------------------
module nios_memory_dp #(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 11,
    parameter int READ_LATENCY   = 1,   // legal values: 1 or 2
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      clken,

    input  logic [ADDR_WIDTH-1:0]     s1_address,
    input  logic                      s1_chipselect,
    input  logic                      s1_read,
    input  logic                      s1_write,
    input  logic [DATA_WIDTH/8-1:0]   s1_byteenable,
    input  logic [DATA_WIDTH-1:0]     s1_writedata,
    output logic [DATA_WIDTH-1:0]     s1_readdata,
    output logic                      s1_readdatavalid,
    output logic                      s1_waitrequest,

    input  logic [ADDR_WIDTH-1:0]     s2_address,
    input  logic                      s2_chipselect,
    input  logic                      s2_read,
    input  logic                      s2_write,
    input  logic [DATA_WIDTH/8-1:0]   s2_byteenable,
    input  logic [DATA_WIDTH-1:0]     s2_writedata,
    output logic [DATA_WIDTH-1:0]     s2_readdata,
    output logic                      s2_readdatavalid,
    output logic                      s2_waitrequest,

`ifdef NIOS_MEMORY_DP_PARITY_EN
    output logic                      parity_err,
`endif
    output logic                      busy
);

    localparam int BE_WIDTH = DATA_WIDTH / 8;
    localparam int DEPTH    = 2 ** ADDR_WIDTH;

    localparam logic [0:0] ST_CLEAR = 1'b0;
    localparam logic [0:0] ST_READY = 1'b1;

    logic [0:0]            state;
    logic [ADDR_WIDTH-1:0] clr_ptr;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic clear_en;
    logic s1_wr_acc, s1_rd_acc;
    logic s2_wr_acc, s2_rd_acc;
    logic s2_collide;

    logic [READ_LATENCY-1:0] s1_pipe_valid;
    logic [READ_LATENCY-1:0] s2_pipe_valid;
    logic [DATA_WIDTH-1:0]   s1_pipe_data [READ_LATENCY];
    logic [DATA_WIDTH-1:0]   s2_pipe_data [READ_LATENCY];

`ifdef NIOS_MEMORY_DP_PARITY_EN
    logic [BE_WIDTH-1:0] par_mem [DEPTH];
    logic [BE_WIDTH-1:0] s1_pipe_par [READ_LATENCY];
    logic [BE_WIDTH-1:0] s2_pipe_par [READ_LATENCY];

    // Even parity per byte: the stored bit makes each 9-bit group even.
    function automatic logic [BE_WIDTH-1:0] byte_parity(input logic [DATA_WIDTH-1:0] d);
        logic [BE_WIDTH-1:0] p;
        p = '0;
        for (int b = 0; b < BE_WIDTH; b++) begin
            p[b] = ^d[b*8 +: 8];
        end
        return p;
    endfunction
`endif

    // Access control. s1 always wins a same-address write collision, so
    // only s2 carries the extra stall term; a stalled s2 read is dropped
    // from this cycle together with the write.
    assign busy           = (state == ST_CLEAR);
    assign clear_en       = (state == ST_CLEAR) & clken;
    assign s1_waitrequest = (state == ST_CLEAR) | ~clken;
    assign s1_wr_acc      = s1_chipselect & s1_write & ~s1_waitrequest;
    assign s1_rd_acc      = s1_chipselect & s1_read & ~s1_write & ~s1_waitrequest;
    assign s2_collide     = (state == ST_READY) & clken & s1_wr_acc &
                            s2_chipselect & s2_write & (s1_address == s2_address);
    assign s2_waitrequest = (state == ST_CLEAR) | ~clken | s2_collide;
    assign s2_wr_acc      = s2_chipselect & s2_write & ~s2_waitrequest;
    assign s2_rd_acc      = s2_chipselect & s2_read & ~s2_write & ~s2_waitrequest;

    // Clear-sweep sequencer: one word per clken cycle, leaving CLEAR on the
    // edge that writes the top word so the sweep spans exactly DEPTH cycles.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_READY;
            clr_ptr <= '0;
        end else if (clear_en) begin
            clr_ptr <= clr_ptr + ADDR_WIDTH'(1);
            if (clr_ptr == ADDR_WIDTH'(DEPTH - 1)) begin
                state <= ST_READY;
            end
        end
    end

    // Memory array. Contents are never reset. Both port writes are applied
    // per byte lane; they can never target the same word in one cycle
    // because s2 is stalled on a collision.
    always_ff @(posedge clk) begin
        if (clear_en) begin
            mem[clr_ptr] <= '0;
`ifdef NIOS_MEMORY_DP_PARITY_EN
            par_mem[clr_ptr] <= '0;
`endif
        end
        if (s2_wr_acc) begin
            for (int b = 0; b < BE_WIDTH; b++) begin
                if (s2_byteenable[b]) begin
                    mem[s2_address][b*8 +: 8] <= s2_writedata[b*8 +: 8];
`ifdef NIOS_MEMORY_DP_PARITY_EN
                    par_mem[s2_address][b] <= ^s2_writedata[b*8 +: 8];
`endif
                end
            end
        end
        if (s1_wr_acc) begin
            for (int b = 0; b < BE_WIDTH; b++) begin
                if (s1_byteenable[b]) begin
                    mem[s1_address][b*8 +: 8] <= s1_writedata[b*8 +: 8];
`ifdef NIOS_MEMORY_DP_PARITY_EN
                    par_mem[s1_address][b] <= ^s1_writedata[b*8 +: 8];
`endif
                end
            end
        end
    end

    // Read pipelines. Stage 0 samples the array at the accept edge, which
    // gives read-first behaviour against a same-cycle write from the other
    // port. The whole pipeline advances only on clken cycles.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_pipe_valid <= '0;
            s2_pipe_valid <= '0;
            for (int i = 0; i < READ_LATENCY; i++) begin
                s1_pipe_data[i] <= '0;
                s2_pipe_data[i] <= '0;
`ifdef NIOS_MEMORY_DP_PARITY_EN
                s1_pipe_par[i] <= '0;
                s2_pipe_par[i] <= '0;
`endif
            end
        end else if (clken) begin
            s1_pipe_valid[0] <= s1_rd_acc;
            s2_pipe_valid[0] <= s2_rd_acc;
            if (s1_rd_acc) begin
                s1_pipe_data[0] <= mem[s1_address];
`ifdef NIOS_MEMORY_DP_PARITY_EN
                s1_pipe_par[0] <= par_mem[s1_address];
`endif
            end
            if (s2_rd_acc) begin
                s2_pipe_data[0] <= mem[s2_address];
`ifdef NIOS_MEMORY_DP_PARITY_EN
                s2_pipe_par[0] <= par_mem[s2_address];
`endif
            end
            for (int i = 1; i < READ_LATENCY; i++) begin
                s1_pipe_valid[i] <= s1_pipe_valid[i-1];
                s2_pipe_valid[i] <= s2_pipe_valid[i-1];
                s1_pipe_data[i]  <= s1_pipe_data[i-1];
                s2_pipe_data[i]  <= s2_pipe_data[i-1];
`ifdef NIOS_MEMORY_DP_PARITY_EN
                s1_pipe_par[i]   <= s1_pipe_par[i-1];
                s2_pipe_par[i]   <= s2_pipe_par[i-1];
`endif
            end
        end
    end

    // The last stage is held while clken is low; gating valid with clken
    // makes each result appear as a single pulse on the cycle it is consumed.
    assign s1_readdata      = s1_pipe_data[READ_LATENCY-1];
    assign s2_readdata      = s2_pipe_data[READ_LATENCY-1];
    assign s1_readdatavalid = s1_pipe_valid[READ_LATENCY-1] & clken;
    assign s2_readdatavalid = s2_pipe_valid[READ_LATENCY-1] & clken;

`ifdef NIOS_MEMORY_DP_PARITY_EN
    // Sticky parity error, checked only on delivered words.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            parity_err <= 1'b0;
        end else if ((s1_readdatavalid &&
                      (byte_parity(s1_readdata) != s1_pipe_par[READ_LATENCY-1])) ||
                     (s2_readdatavalid &&
                      (byte_parity(s2_readdata) != s2_pipe_par[READ_LATENCY-1]))) begin
            parity_err <= 1'b1;
        end
    end
`endif

endmodule
